// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU / host) round-robin arbiter driving a four-phase AS_N/ACK_N
// memory handshake with per-phase timeout and a sticky error flag.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          CPU_MR,
  input  logic          CPU_MW,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_BUSY,
  input  logic          HOST_RD,
  input  logic          HOST_WR,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [DW-1:0] HOST_WDATA,
  output logic          HOST_BUSY,
  output logic [DW-1:0] RD_DATA,
  output logic          AS_N,
  output logic          WR_N,
  output logic [AW-1:0] BUS_ADDR,
  output logic [DW-1:0] BUS_WDATA,
  input  logic [DW-1:0] BUS_RDATA,
  input  logic          ACK_N,
  output logic          GNT_CPU,
  output logic          GNT_HOST,
  output logic          BUS_ERR,
  input  logic          ERR_CLR,
  output logic [1:0]    STATE_DBG
);

  // Requester handshake: a request is a level held until the requester sees
  // its BUSY low; BUSY drops for exactly the DONE cycle of its own transaction.
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, RELEASE = 2'd2, DONE = 2'd3} state_t;

  state_t     state, state_nxt;
  logic       ack_m, ack_s;
  logic [7:0] cnt;
  logic       last_host;
  logic       req_cpu, req_host, pick_host, grant_wr, grant, timeout;
  logic       cap_rd, err_set;

  assign req_cpu   = CPU_MR | CPU_MW;
  assign req_host  = HOST_RD | HOST_WR;
  // Host wins only when alone or when the CPU had the previous grant.
  assign pick_host = req_host & (~req_cpu | ~last_host);
  assign grant_wr  = pick_host ? (HOST_WR & ~HOST_RD) : (CPU_MW & ~CPU_MR);
  assign timeout   = (cnt == 8'(TIMEOUT - 1));
  assign STATE_DBG = state;
  assign CPU_BUSY  = req_cpu  & ~((state == DONE) & GNT_CPU);
  assign HOST_BUSY = req_host & ~((state == DONE) & GNT_HOST);

  // ACK_N is asynchronous; only the second flop feeds the FSM.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ack_m <= 1'b1;
      ack_s <= 1'b1;
    end else begin
      ack_m <= ACK_N;
      ack_s <= ack_m;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= 8'd0;
      else if (state == ASSERT || state == RELEASE)
        cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    cap_rd    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req_cpu || req_host) begin
          grant     = 1'b1;
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (!ack_s) begin
          cap_rd    = WR_N;
          state_nxt = RELEASE;
        end else if (timeout) begin
          err_set   = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (ack_s) begin
          state_nxt = DONE;
        end else if (timeout) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      AS_N      <= 1'b1;
      WR_N      <= 1'b1;
      BUS_ADDR  <= '0;
      BUS_WDATA <= '0;
      RD_DATA   <= '0;
      GNT_CPU   <= 1'b0;
      GNT_HOST  <= 1'b0;
      BUS_ERR   <= 1'b0;
      last_host <= 1'b1;
    end else begin
      AS_N <= (state_nxt != ASSERT);
      if (grant) begin
        GNT_CPU  <= ~pick_host;
        GNT_HOST <= pick_host;
        BUS_ADDR <= pick_host ? HOST_ADDR : CPU_ADDR;
        WR_N     <= ~grant_wr;
        if (grant_wr)
          BUS_WDATA <= pick_host ? HOST_WDATA : CPU_WDATA;
      end
      if (cap_rd)
        RD_DATA <= BUS_RDATA;
      if (state == DONE) begin
        GNT_CPU   <= 1'b0;
        GNT_HOST  <= 1'b0;
        WR_N      <= 1'b1;
        last_host <= GNT_HOST;
      end
      if (err_set)
        BUS_ERR <= 1'b1;
      else if (ERR_CLR)
        BUS_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a behavioural memory slave answers AS_N
// after a programmable delay (or never), and each scenario task checks inline.
module tb_mem_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CPU_MR = 1'b0, CPU_MW = 1'b0;
  logic [31:0] CPU_ADDR = '0, CPU_WDATA = '0;
  logic        CPU_BUSY;
  logic        HOST_RD = 1'b0, HOST_WR = 1'b0;
  logic [31:0] HOST_ADDR = '0, HOST_WDATA = '0;
  logic        HOST_BUSY;
  logic [31:0] RD_DATA;
  logic        AS_N, WR_N;
  logic [31:0] BUS_ADDR, BUS_WDATA;
  logic [31:0] BUS_RDATA = '0;
  logic        ACK_N = 1'b1;
  logic        GNT_CPU, GNT_HOST, BUS_ERR;
  logic        ERR_CLR = 1'b0;
  logic [1:0]  STATE_DBG;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic slave_en = 1'b0;
  int   slave_delay = 0;
  int   as_cnt = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_MR(CPU_MR), .CPU_MW(CPU_MW), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_BUSY(CPU_BUSY),
    .HOST_RD(HOST_RD), .HOST_WR(HOST_WR), .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA),
    .HOST_BUSY(HOST_BUSY),
    .RD_DATA(RD_DATA), .AS_N(AS_N), .WR_N(WR_N), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .ACK_N(ACK_N),
    .GNT_CPU(GNT_CPU), .GNT_HOST(GNT_HOST), .BUS_ERR(BUS_ERR), .ERR_CLR(ERR_CLR),
    .STATE_DBG(STATE_DBG)
  );

  always #5 CLK = ~CLK;

  // Slave: pulls ACK_N low slave_delay cycles into the AS_N-low window and
  // releases it in the cycle AS_N returns high.
  always @(posedge CLK) begin
    #1;
    if (!AS_N && slave_en) begin
      if (as_cnt >= slave_delay) ACK_N = 1'b0;
      as_cnt++;
    end else begin
      as_cnt = 0;
      ACK_N  = 1'b1;
    end
  end

  task automatic wait_done(input bit host, output int n, output int as_low,
                           output bit wr_hi, output bit wr_lo);
    n = 0; as_low = 0; wr_hi = 1'b0; wr_lo = 1'b0;
    @(negedge CLK);
    while ((host ? HOST_BUSY : CPU_BUSY) && n < 200) begin
      n++;
      if (!AS_N) begin
        as_low++;
        if (WR_N) wr_hi = 1'b1; else wr_lo = 1'b1;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    vec_cnt++; if (AS_N !== 1'b1) begin err_cnt++; $display("FAIL rst_as_n: got %b want 1", AS_N); end
    vec_cnt++; if (WR_N !== 1'b1) begin err_cnt++; $display("FAIL rst_wr_n: got %b want 1", WR_N); end
    vec_cnt++; if (BUS_ADDR !== 32'h0) begin err_cnt++; $display("FAIL rst_addr: got %h want 0", BUS_ADDR); end
    vec_cnt++; if (BUS_WDATA !== 32'h0) begin err_cnt++; $display("FAIL rst_wdata: got %h want 0", BUS_WDATA); end
    vec_cnt++; if (RD_DATA !== 32'h0) begin err_cnt++; $display("FAIL rst_rd_data: got %h want 0", RD_DATA); end
    vec_cnt++; if ({GNT_CPU, GNT_HOST} !== 2'b00) begin err_cnt++; $display("FAIL rst_gnt: got %b want 00", {GNT_CPU, GNT_HOST}); end
    vec_cnt++; if (BUS_ERR !== 1'b0) begin err_cnt++; $display("FAIL rst_bus_err: got %b want 0", BUS_ERR); end
    vec_cnt++; if (STATE_DBG !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", STATE_DBG); end
    CPU_MR = 1'b1;
    #1;
    vec_cnt++; if ({CPU_BUSY, HOST_BUSY} !== 2'b10) begin err_cnt++; $display("FAIL rst_busy_follow: got %b want 10", {CPU_BUSY, HOST_BUSY}); end
    CPU_MR = 1'b0;
    @(posedge CLK); #1 RESET_N = 1'b1;
  endtask

  task automatic test_cpu_read;
    int n, as_low; bit wr_hi, wr_lo;
    @(posedge CLK); #1;
    slave_en = 1'b1; slave_delay = 2; BUS_RDATA = 32'hDEADBEEF;
    CPU_ADDR = 32'h10; CPU_MR = 1'b1;
    #1;
    vec_cnt++; if (CPU_BUSY !== 1'b1) begin err_cnt++; $display("FAIL rd_busy_rise: got %b want 1", CPU_BUSY); end
    wait_done(1'b0, n, as_low, wr_hi, wr_lo);
    vec_cnt++; if (n !== 9) begin err_cnt++; $display("FAIL rd_latency: got %0d want 9", n); end
    vec_cnt++; if (as_low !== 5) begin err_cnt++; $display("FAIL rd_as_low: got %0d want 5", as_low); end
    vec_cnt++; if ({wr_hi, wr_lo} !== 2'b10) begin err_cnt++; $display("FAIL rd_wr_n: got hi/lo %b want 10", {wr_hi, wr_lo}); end
    vec_cnt++; if (RD_DATA !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rd_data: got %h want deadbeef", RD_DATA); end
    vec_cnt++; if (BUS_ADDR !== 32'h10) begin err_cnt++; $display("FAIL rd_addr: got %h want 10", BUS_ADDR); end
    @(negedge CLK);
    vec_cnt++; if (CPU_BUSY !== 1'b1) begin err_cnt++; $display("FAIL rd_busy_pulse: got %b want 1", CPU_BUSY); end
    CPU_MR = 1'b0;
  endtask

  task automatic test_host_write;
    int n, as_low; bit wr_hi, wr_lo;
    @(posedge CLK); #1;
    slave_en = 1'b1; slave_delay = 0; BUS_RDATA = 32'hCAFEF00D;
    HOST_ADDR = 32'h20; HOST_WDATA = 32'h12345678; HOST_WR = 1'b1;
    wait_done(1'b1, n, as_low, wr_hi, wr_lo);
    vec_cnt++; if (n !== 7) begin err_cnt++; $display("FAIL wr_latency: got %0d want 7", n); end
    vec_cnt++; if (as_low !== 3) begin err_cnt++; $display("FAIL wr_as_low: got %0d want 3", as_low); end
    vec_cnt++; if ({wr_hi, wr_lo} !== 2'b01) begin err_cnt++; $display("FAIL wr_wr_n: got hi/lo %b want 01", {wr_hi, wr_lo}); end
    vec_cnt++; if (BUS_ADDR !== 32'h20) begin err_cnt++; $display("FAIL wr_addr: got %h want 20", BUS_ADDR); end
    vec_cnt++; if (BUS_WDATA !== 32'h12345678) begin err_cnt++; $display("FAIL wr_wdata: got %h want 12345678", BUS_WDATA); end
    vec_cnt++; if (RD_DATA !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL wr_rd_data_hold: got %h want deadbeef", RD_DATA); end
    @(negedge CLK);
    vec_cnt++; if (HOST_BUSY !== 1'b1) begin err_cnt++; $display("FAIL wr_busy_pulse: got %b want 1", HOST_BUSY); end
    vec_cnt++; if ({GNT_CPU, GNT_HOST, WR_N} !== 3'b001) begin err_cnt++; $display("FAIL wr_after_done: got %b want 001", {GNT_CPU, GNT_HOST, WR_N}); end
    HOST_WR = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n; bit both_gnt; bit who;
    logic [2:0] exp_order;
    exp_order = 3'b010;
    both_gnt = 1'b0;
    @(posedge CLK); #1 RESET_N = 1'b0;
    @(posedge CLK); #1 RESET_N = 1'b1;
    slave_en = 1'b1; slave_delay = 0; BUS_RDATA = 32'h0BADF00D;
    CPU_ADDR = 32'h30; HOST_ADDR = 32'h34;
    CPU_MR = 1'b1; HOST_RD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge CLK);
        n++;
        if (GNT_CPU && GNT_HOST) both_gnt = 1'b1;
      end while (CPU_BUSY && HOST_BUSY && n < 100);
      who = CPU_BUSY;
      vec_cnt++; if (who !== exp_order[i]) begin err_cnt++; $display("FAIL rr_order[%0d]: got host=%b want host=%b", i, who, exp_order[i]); end
      vec_cnt++; if (n !== 8) begin err_cnt++; $display("FAIL rr_spacing[%0d]: got %0d want 8", i, n); end
    end
    CPU_MR = 1'b0; HOST_RD = 1'b0;
    vec_cnt++; if (both_gnt !== 1'b0) begin err_cnt++; $display("FAIL rr_both_gnt: got %b want 0", both_gnt); end
    vec_cnt++; if (RD_DATA !== 32'h0BADF00D) begin err_cnt++; $display("FAIL rr_rd_data: got %h want 0badf00d", RD_DATA); end
  endtask

  task automatic test_timeout;
    int n, as_low, k; bit wr_hi, wr_lo, seen_low;
    @(posedge CLK); #1;
    slave_en = 1'b0;
    CPU_ADDR = 32'h40; CPU_WDATA = 32'hA5A5A5A5; CPU_MW = 1'b1;
    wait_done(1'b0, n, as_low, wr_hi, wr_lo);
    vec_cnt++; if (n !== 17) begin err_cnt++; $display("FAIL to_latency: got %0d want 17", n); end
    vec_cnt++; if (as_low !== 15) begin err_cnt++; $display("FAIL to_as_low: got %0d want 15", as_low); end
    vec_cnt++; if (wr_lo !== 1'b1) begin err_cnt++; $display("FAIL to_wr_n: got wr_lo %b want 1", wr_lo); end
    vec_cnt++; if (BUS_ERR !== 1'b1) begin err_cnt++; $display("FAIL to_err_set: got %b want 1", BUS_ERR); end
    vec_cnt++; if (BUS_WDATA !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL to_wdata: got %h want a5a5a5a5", BUS_WDATA); end
    CPU_MW = 1'b0;
    repeat (3) @(negedge CLK);
    vec_cnt++; if (BUS_ERR !== 1'b1) begin err_cnt++; $display("FAIL to_err_sticky: got %b want 1", BUS_ERR); end
    @(posedge CLK); #1 ERR_CLR = 1'b1;
    @(posedge CLK); #1 ERR_CLR = 1'b0;
    @(negedge CLK);
    vec_cnt++; if (BUS_ERR !== 1'b0) begin err_cnt++; $display("FAIL to_err_clr: got %b want 0", BUS_ERR); end
    // host read timing out while ERR_CLR is held: the set must win on that edge
    @(posedge CLK); #1;
    BUS_RDATA = 32'hFFFFFFFF; HOST_ADDR = 32'h44; HOST_RD = 1'b1; ERR_CLR = 1'b1;
    seen_low = 1'b0; k = 0;
    while (k < 100 && !(seen_low && AS_N)) begin
      @(negedge CLK);
      if (!AS_N) seen_low = 1'b1;
      k++;
    end
    vec_cnt++; if (BUS_ERR !== 1'b1) begin err_cnt++; $display("FAIL to_set_wins: got %b want 1", BUS_ERR); end
    @(negedge CLK);
    vec_cnt++; if (BUS_ERR !== 1'b0) begin err_cnt++; $display("FAIL to_clr_after: got %b want 0", BUS_ERR); end
    vec_cnt++; if (HOST_BUSY !== 1'b0) begin err_cnt++; $display("FAIL to_host_done: got %b want 0", HOST_BUSY); end
    vec_cnt++; if (RD_DATA !== 32'h0BADF00D) begin err_cnt++; $display("FAIL to_rd_data_hold: got %h want 0badf00d", RD_DATA); end
    HOST_RD = 1'b0; ERR_CLR = 1'b0;
  endtask

  task automatic test_reset_mid_txn;
    int n, as_low; bit wr_hi, wr_lo;
    @(posedge CLK); #1;
    slave_en = 1'b0; BUS_RDATA = 32'h5EED1234;
    CPU_ADDR = 32'h50; CPU_MR = 1'b1;
    repeat (4) @(negedge CLK);
    vec_cnt++; if ({AS_N, GNT_CPU} !== 2'b01) begin err_cnt++; $display("FAIL mid_pre: got %b want 01", {AS_N, GNT_CPU}); end
    RESET_N = 1'b0;
    #1;
    vec_cnt++; if (AS_N !== 1'b1) begin err_cnt++; $display("FAIL mid_as_n: got %b want 1", AS_N); end
    vec_cnt++; if (GNT_CPU !== 1'b0) begin err_cnt++; $display("FAIL mid_gnt: got %b want 0", GNT_CPU); end
    vec_cnt++; if (STATE_DBG !== 2'd0) begin err_cnt++; $display("FAIL mid_state: got %0d want 0", STATE_DBG); end
    slave_en = 1'b1; slave_delay = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      vec_cnt++; if (CPU_BUSY !== 1'b1) begin err_cnt++; $display("FAIL mid_busy[%0d]: got %b want 1", i, CPU_BUSY); end
    end
    @(posedge CLK); #1 RESET_N = 1'b1;
    wait_done(1'b0, n, as_low, wr_hi, wr_lo);
    vec_cnt++; if (n !== 7) begin err_cnt++; $display("FAIL mid_restart: got %0d want 7", n); end
    vec_cnt++; if (as_low !== 3) begin err_cnt++; $display("FAIL mid_as_low: got %0d want 3", as_low); end
    vec_cnt++; if (RD_DATA !== 32'h5EED1234) begin err_cnt++; $display("FAIL mid_rd_data: got %h want 5eed1234", RD_DATA); end
    CPU_MR = 1'b0;
  endtask

  task automatic test_read_wins;
    int n, as_low; bit wr_hi, wr_lo;
    @(posedge CLK); #1;
    slave_en = 1'b1; slave_delay = 1; BUS_RDATA = 32'h600DCAFE;
    CPU_ADDR = 32'h60; CPU_WDATA = 32'h55AA55AA; CPU_MR = 1'b1; CPU_MW = 1'b1;
    wait_done(1'b0, n, as_low, wr_hi, wr_lo);
    vec_cnt++; if (n !== 8) begin err_cnt++; $display("FAIL rw_latency: got %0d want 8", n); end
    vec_cnt++; if (as_low !== 4) begin err_cnt++; $display("FAIL rw_as_low: got %0d want 4", as_low); end
    vec_cnt++; if ({wr_hi, wr_lo} !== 2'b10) begin err_cnt++; $display("FAIL rw_wr_n: got hi/lo %b want 10", {wr_hi, wr_lo}); end
    vec_cnt++; if (RD_DATA !== 32'h600DCAFE) begin err_cnt++; $display("FAIL rw_rd_data: got %h want 600dcafe", RD_DATA); end
    vec_cnt++; if (BUS_WDATA !== 32'h0) begin err_cnt++; $display("FAIL rw_wdata_hold: got %h want 0", BUS_WDATA); end
    vec_cnt++; if (BUS_ADDR !== 32'h60) begin err_cnt++; $display("FAIL rw_addr: got %h want 60", BUS_ADDR); end
    CPU_MR = 1'b0; CPU_MW = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_host_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid_txn();
    test_read_wins();
    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
